// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU step/run controller.
// Holds the mode enum, run-speed encodings and the prescaler period lookup.
package cpu_ctrl_pkg;

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PRESC_W = 6;

  localparam logic [1:0] SPD_P1  = 2'd0;
  localparam logic [1:0] SPD_P4  = 2'd1;
  localparam logic [1:0] SPD_P16 = 2'd2;
  localparam logic [1:0] SPD_P64 = 2'd3;

  // Terminal prescaler value P-1 for P = 4^spd.
  function automatic logic [PRESC_W-1:0] period_max(
    input logic [1:0] spd
  );
    logic [PRESC_W-1:0] m;
    m = '0;
    unique case (spd)
      SPD_P1:  m = 6'd0;
      SPD_P4:  m = 6'd3;
      SPD_P16: m = 6'd15;
      SPD_P64: m = 6'd63;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer.
// A new level is accepted after DEBOUNCE_CYCLES consecutive synced cycles.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stable_q;
  logic          stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: single-step on button, free-run at a
// switch-selected rate, with debounced switches and a pulse counter.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_step,
  input  logic [2:0]           switches,
  output logic                 cpu_en,
  output logic [2:0]           sw_db,
  output logic [CNT_WIDTH-1:0] step_count
);

  logic [3:0] raw;
  logic [3:0] db;

  assign raw = {btn_step, switches};

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw[i]),
      .stable_o(db[i])
    );
  end

  logic btn_db;
  assign btn_db = db[3];
  assign sw_db  = db[2:0];

  state_e               state_q;
  state_e               state_d;
  logic                 btn_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_d;
  logic [1:0]           spd_q;
  logic                 pulse_q;
  logic                 pulse_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic btn_rise;
  logic spd_chg;
  logic run_hit;
  logic en;

  always_comb begin
    btn_rise = btn_db & ~btn_q;
    spd_chg  = (sw_db[1:0] != spd_q);
    run_hit  = (state_q == ST_RUN) &&
               (presc_q == period_max(spd_q));
    en       = (state_q == ST_STEP) ? pulse_q : run_hit;
    state_d  = state_q;
    presc_d  = presc_q;
    pulse_d  = 1'b0;
    unique case (state_q)
      ST_STEP: begin
        presc_d = '0;
        // A press coinciding with entry to RUN is dropped.
        pulse_d = btn_rise & ~sw_db[2];
        if (sw_db[2]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!sw_db[2]) begin
          state_d = ST_STEP;
          presc_d = '0;
        end else if (spd_chg || run_hit) begin
          presc_d = '0;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
    endcase
    cnt_d = cnt_q + CNT_WIDTH'(en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_STEP;
      btn_q   <= 1'b0;
      presc_q <= '0;
      spd_q   <= 2'b00;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_db;
      presc_q <= presc_d;
      spd_q   <= sw_db[1:0];
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_en     = en;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4.
// Edge k = k-th rising edge after inputs change; outputs sampled 1ns after.
module tb_cpu_step_ctrl;

  logic       clock;
  logic       reset;
  logic       btn_step;
  logic [2:0] switches;
  logic       cpu_en;
  logic [2:0] sw_db;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_step  (btn_step),
    .switches  (switches),
    .cpu_en    (cpu_en),
    .sw_db     (sw_db),
    .step_count(step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [2:0] sw;
    int         cyc;
    int         en;
    int         swdb;
    int         cnt;
  } vec_t;

  vec_t tbl[19];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    btn_step = 1'b0;
    switches = 3'b000;
    tick();
    tick();
    chk("rst_en", int'(cpu_en), 0);
    chk("rst_swdb", int'(sw_db), 0);
    chk("rst_cnt", int'(step_count), 0);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    int pedge;
    int ngap;

    // Run-mode script: period 4, reset mid-period, speed change, exit.
    tbl[0]  = '{1'b1, 1'b0, 3'b000,  2, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 3'b101,  5, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 3'b101,  1, 0, 5, 0};
    tbl[3]  = '{1'b0, 1'b0, 3'b101,  4, 1, 5, 0};
    tbl[4]  = '{1'b0, 1'b0, 3'b101,  1, 0, 5, 1};
    tbl[5]  = '{1'b0, 1'b0, 3'b101, 63, 1, 5, 16};
    tbl[6]  = '{1'b0, 1'b0, 3'b101,  1, 0, 5, 17};
    tbl[7]  = '{1'b1, 1'b0, 3'b101,  1, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 3'b101,  5, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 3'b101,  1, 0, 5, 0};
    tbl[10] = '{1'b0, 1'b0, 3'b101,  4, 1, 5, 0};
    tbl[11] = '{1'b0, 1'b0, 3'b101,  1, 0, 5, 1};
    tbl[12] = '{1'b0, 1'b0, 3'b110,  6, 0, 6, 2};
    tbl[13] = '{1'b0, 1'b0, 3'b110,  1, 0, 6, 2};
    tbl[14] = '{1'b0, 1'b0, 3'b110, 15, 1, 6, 2};
    tbl[15] = '{1'b0, 1'b0, 3'b110,  1, 0, 6, 3};
    tbl[16] = '{1'b0, 1'b0, 3'b000,  6, 0, 0, 3};
    tbl[17] = '{1'b0, 1'b0, 3'b000,  1, 0, 0, 3};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 20, 0, 0, 3};

    reset    = 1'b1;
    btn_step = 1'b0;
    switches = 3'b000;

    // Held button: one pulse, visible after edge 7.
    do_reset();
    btn_step = 1'b1;
    npulse   = 0;
    pedge    = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cpu_en) begin
        npulse++;
        if (pedge == 0) pedge = k;
      end
    end
    chk("hold_pulses", npulse, 1);
    chk("hold_edge", pedge, 7);
    chk("hold_cnt", int'(step_count), 1);
    btn_step = 1'b0;
    repeat (10) tick();
    chk("hold_cnt_rel", int'(step_count), 1);

    // Three-cycle glitch is filtered.
    do_reset();
    btn_step = 1'b1;
    repeat (3) tick();
    btn_step = 1'b0;
    npulse   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cpu_en) npulse++;
    end
    chk("glitch_pulses", npulse, 0);
    chk("glitch_cnt", int'(step_count), 0);

    for (int i = 0; i < 19; i++) begin
      reset    = tbl[i].rst;
      btn_step = tbl[i].btn;
      switches = tbl[i].sw;
      repeat (tbl[i].cyc) tick();
      chk($sformatf("row%0d_en", i), int'(cpu_en), tbl[i].en);
      chk($sformatf("row%0d_swdb", i), int'(sw_db), tbl[i].swdb);
      chk($sformatf("row%0d_cnt", i), int'(step_count), tbl[i].cnt);
    end
    reset = 1'b0;

    // P=1: continuous enable from edge 7, counter wraps.
    do_reset();
    switches = 3'b100;
    ngap     = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 6) chk("p1_en_pre", int'(cpu_en), 0);
      if (k >= 7 && !cpu_en) ngap++;
      if (k == 262) chk("p1_cnt_255", int'(step_count), 255);
      if (k == 263) chk("p1_cnt_wrap", int'(step_count), 0);
    end
    chk("p1_gaps", ngap, 0);
    chk("p1_cnt_end", int'(step_count), 37);

    // Leave RUN with the button held; only a fresh press steps.
    do_reset();
    switches = 3'b111;
    btn_step = 1'b1;
    ngap     = 0;
    npulse   = 0;
    pedge    = 0;
    for (int k = 1; k <= 90; k++) begin
      if (k == 31) switches = 3'b011;
      if (k == 61) btn_step = 1'b0;
      if (k == 71) btn_step = 1'b1;
      tick();
      if (k >= 37 && k <= 70 && cpu_en) ngap++;
      if (cpu_en) begin
        npulse++;
        if (pedge == 0) pedge = k;
      end
    end
    chk("exit_held_en", ngap, 0);
    chk("exit_pulses", npulse, 1);
    chk("exit_edge", pedge, 77);
    chk("exit_cnt", int'(step_count), 1);
    chk("exit_swdb", int'(sw_db), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
